// File: rtl/id_ex_operand_stage.sv
//------------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register sitting directly in front of the 32-bit ALU.
// It captures the decoded instruction and register-file operands, and on
// the way in it:
//   - builds the ALU A/B operands (immediate extension, shift amount),
//   - resolves the destination register (rt or rd),
//   - suppresses register writes to $zero,
//   - traps ALU codes above MAX_ALUCTL: it loads a bubble and raises a
//     sticky flag that only Reset clears.
// The stage can hold its contents (Stall) or load a bubble (Flush).
// All outputs are registered with a latency of one cycle.
//
// Per-edge priority: Reset > Flush > Stall > load.
//
// Ports
//   Clk                 in   1   pipeline clock, rising edge
//   Reset               in   1   synchronous, active-high reset
//   Stall               in   1   hold every registered output
//   Flush               in   1   load a bubble (wins over Stall)
//   In_Valid            in   1   ID stage presents a real instruction
//   In_ALUControl       in   4   decoded ALU op code
//   In_ReadData1/2      in   32  register-file rs / rt values
//   In_Imm16            in   16  instruction immediate field
//   In_Shamt            in   5   instruction shamt field
//   In_Rt, In_Rd        in   5   rt / rd register numbers
//   In_ALUSrc           in   1   B takes the extended immediate
//   In_ShiftOp          in   1   sll/srl: A takes shamt, B takes rt
//   In_ZeroExt          in   1   zero-extend (1) or sign-extend (0) Imm16
//   In_RegDst           in   1   destination is rd (1) or rt (0)
//   In_RegWrite, In_MemRead, In_MemWrite, In_MemToReg   in  1  control
//   Out_Valid           out  1   registered valid
//   ALUControl          out  4   ALU op code
//   A, B                out  32  ALU operands
//   Out_WriteData       out  32  store data (registered rt value)
//   Out_WriteReg        out  5   resolved destination register
//   Out_RegWrite, Out_MemRead, Out_MemWrite, Out_MemToReg  out  1  control
//   Out_IllegalOp       out  1   sticky illegal-ALU-code flag
//------------------------------------------------------------------------------
module id_ex_operand_stage #(
   parameter int MAX_ALUCTL = 9
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        In_Valid,
   input  logic [3:0]  In_ALUControl,
   input  logic [31:0] In_ReadData1,
   input  logic [31:0] In_ReadData2,
   input  logic [15:0] In_Imm16,
   input  logic [4:0]  In_Shamt,
   input  logic [4:0]  In_Rt,
   input  logic [4:0]  In_Rd,
   input  logic        In_ALUSrc,
   input  logic        In_ShiftOp,
   input  logic        In_ZeroExt,
   input  logic        In_RegDst,
   input  logic        In_RegWrite,
   input  logic        In_MemRead,
   input  logic        In_MemWrite,
   input  logic        In_MemToReg,
   output logic        Out_Valid,
   output logic [3:0]  ALUControl,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [31:0] Out_WriteData,
   output logic [4:0]  Out_WriteReg,
   output logic        Out_RegWrite,
   output logic        Out_MemRead,
   output logic        Out_MemWrite,
   output logic        Out_MemToReg,
   output logic        Out_IllegalOp
);

   localparam logic [3:0] MAX_CODE = 4'(MAX_ALUCTL);

   // Everything the stage carries for one instruction. An all-zero value is
   // the bubble: invalid, ALU op 0 with zero operands, no side effects.
   typedef struct packed {
      logic        valid;
      logic [3:0]  alu_ctl;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [31:0] write_data;
      logic [4:0]  write_reg;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
   } stage_t;

   localparam stage_t BUBBLE = '0;

   stage_t stage_q, stage_d;
   logic   illegal_q, illegal_d;

   //---------------------------------------------------------------------------
   // Operand and destination preparation for the instruction being offered.
   //---------------------------------------------------------------------------
   logic [31:0] ext_imm;
   logic [4:0]  dest_reg;
   logic        code_legal;
   stage_t      loaded;

   assign ext_imm    = In_ZeroExt ? {16'b0, In_Imm16}
                                  : {{16{In_Imm16[15]}}, In_Imm16};
   assign dest_reg   = In_RegDst ? In_Rd : In_Rt;
   assign code_legal = (In_ALUControl <= MAX_CODE);

   always_comb begin
      loaded            = BUBBLE;
      loaded.valid      = 1'b1;
      loaded.alu_ctl    = In_ALUControl;
      loaded.write_data = In_ReadData2;
      loaded.write_reg  = dest_reg;
      // Writes to $zero are dropped here, but the register number is still
      // forwarded so hazard logic downstream sees the real destination.
      loaded.reg_write  = In_RegWrite & (dest_reg != 5'd0);
      loaded.mem_read   = In_MemRead;
      loaded.mem_write  = In_MemWrite;
      loaded.mem_to_reg = In_MemToReg;
      if (In_ShiftOp) begin
         // Shifts: the ALU computes B << A / B >> A, so the shift amount
         // rides on A and the value to shift (rt) on B. ALUSrc is ignored.
         loaded.op_a = {27'b0, In_Shamt};
         loaded.op_b = In_ReadData2;
      end else begin
         loaded.op_a = In_ReadData1;
         loaded.op_b = In_ALUSrc ? ext_imm : In_ReadData2;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state selection: Flush > Stall > load (Reset is applied in the
   // register block below so it wins over everything).
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first (hold); a path
      // that skipped one would infer a latch instead of plain muxing.
      stage_d   = stage_q;
      illegal_d = illegal_q;
      if (Flush) begin
         // The sticky flag survives a flush and an illegal code under
         // flush is not trapped.
         stage_d = BUBBLE;
      end else if (!Stall) begin
         if (!In_Valid) begin
            stage_d = BUBBLE;
         end else if (!code_legal) begin
            // Never forward an undefined ALU code: replace with a bubble.
            stage_d   = BUBBLE;
            illegal_d = 1'b1;
         end else begin
            stage_d = loaded;
         end
      end
   end

   //---------------------------------------------------------------------------
   // State registers with synchronous reset.
   //---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (Reset) begin
         stage_q   <= BUBBLE;
         illegal_q <= 1'b0;
      end else begin
         stage_q   <= stage_d;
         illegal_q <= illegal_d;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs.
   //---------------------------------------------------------------------------
   assign Out_Valid     = stage_q.valid;
   assign ALUControl    = stage_q.alu_ctl;
   assign A             = stage_q.op_a;
   assign B             = stage_q.op_b;
   assign Out_WriteData = stage_q.write_data;
   assign Out_WriteReg  = stage_q.write_reg;
   assign Out_RegWrite  = stage_q.reg_write;
   assign Out_MemRead   = stage_q.mem_read;
   assign Out_MemWrite  = stage_q.mem_write;
   assign Out_MemToReg  = stage_q.mem_to_reg;
   assign Out_IllegalOp = illegal_q;

endmodule
